// File: rtl/mpp_po_tracker_if.sv
// Tracker bus: the filtered-power sample and enable go in; the converter
// reference, its direction and the status flags come out.
interface mpp_po_tracker_if #(
  parameter int DW = 24
);
  logic                 en;
  logic signed [DW-1:0] din;
  logic [15:0]          vref;
  logic                 dir;
  logic                 upd;
  logic                 busy;

  modport master (output en, output din, input vref, input dir, input upd, input busy);
  modport slave  (input en, input din, output vref, output dir, output upd, output busy);
endinterface

// File: rtl/mpp_po_tracker.sv
// Perturb-and-observe MPP tracker: perturb vref, settle, average N filtered
// power samples, compare with the previous window and step toward higher power.
module mpp_po_tracker #(
  parameter int DW        = 24,
  parameter int SETTLE    = 16,
  parameter int AVG_LOG2  = 3,
  parameter int STEP      = 64,
  parameter int VREF_INIT = 32768,
  parameter int VREF_MIN  = 1024,
  parameter int VREF_MAX  = 64512
) (
  input  logic             clk,
  input  logic             rst_n,
  mpp_po_tracker_if.slave  bus
);
  localparam int N    = 1 << AVG_LOG2;
  localparam int AW   = DW + AVG_LOG2;
  localparam int MAXC = (SETTLE > N) ? SETTLE : N;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic signed [17:0] STEP_S = 18'(STEP);
  localparam logic signed [17:0] VMAX_S = 18'(VREF_MAX);
  localparam logic signed [17:0] VMIN_S = 18'(VREF_MIN);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_DECIDE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic signed [AW-1:0] acc_q;
  logic signed [DW-1:0] prev_q;
  logic                 have_prev_q;
  logic [15:0]          vref_q;
  logic                 dir_q;
  logic                 upd_q;
  logic                 busy_q;

  logic signed [AW-1:0] acc_d;
  logic signed [DW-1:0] avg_d;
  logic                 dir_pick;
  logic signed [17:0]   vref_sum;
  logic [15:0]          vref_d;
  logic                 dir_d;

  // Decision datapath; only consumed in DECIDE and while accumulating.
  always_comb begin
    acc_d    = acc_q + AW'(bus.din);
    avg_d    = DW'(acc_q >>> AVG_LOG2);
    dir_pick = (have_prev_q && (avg_d < prev_q)) ? ~dir_q : dir_q;
    vref_sum = dir_pick ? ($signed({2'b00, vref_q}) + STEP_S)
                        : ($signed({2'b00, vref_q}) - STEP_S);
    vref_d   = 16'(vref_sum);
    dir_d    = dir_pick;
    if (vref_sum > VMAX_S) begin
      vref_d = 16'(VREF_MAX);
      dir_d  = ~dir_pick;
    end else if (vref_sum < VMIN_S) begin
      vref_d = 16'(VREF_MIN);
      dir_d  = ~dir_pick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      vref_q      <= 16'(VREF_INIT);
      dir_q       <= 1'b1;
      upd_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      // Dropping enable outside DECIDE abandons the window and forgets history.
      if (!bus.en && (state_q == S_SETTLE || state_q == S_ACCUM)) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        acc_q       <= '0;
        have_prev_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.en) begin
              state_q <= S_SETTLE;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1)) begin
              state_q <= S_ACCUM;
              cnt_q   <= '0;
              acc_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_ACCUM: begin
            acc_q <= acc_d;
            if (cnt_q == CW'(N - 1)) begin
              state_q <= S_DECIDE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DECIDE: begin
            vref_q      <= vref_d;
            dir_q       <= dir_d;
            prev_q      <= avg_d;
            have_prev_q <= 1'b1;
            upd_q       <= 1'b1;
            cnt_q       <= '0;
            state_q     <= bus.en ? S_SETTLE : S_IDLE;
            busy_q      <= bus.en;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.vref = vref_q;
  assign bus.dir  = dir_q;
  assign bus.upd  = upd_q;
  assign bus.busy = busy_q;
endmodule
